// File: rtl/fpu_issue_sequencer.sv
// EX-stage sequencer for multi-cycle FP operations: stalls the pipeline for the
// operation's fixed latency, strobes the FPU start and emits one writeback strobe.
module fpu_issue_sequencer #(
  parameter int LAT_ADDSUB = 2,
  parameter int LAT_MUL    = 3,
  parameter int LAT_DIV    = 16,
  parameter int LAT_SQRT   = 16,
  parameter int LAT_MISC   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       issue_valid,
  input  logic [3:0] op_code,
  input  logic [4:0] rd,
  input  logic       float_wr,
  input  logic       int_wr,
  input  logic       flush,
  output logic       stall,
  output logic       fpu_start,
  output logic [3:0] fpu_op,
  output logic       busy,
  output logic       wb_valid,
  output logic [4:0] wb_rd,
  output logic       wb_float,
  output logic       wb_int,
  output logic       op_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [4:0] LAT_ADDSUB_W = 5'(LAT_ADDSUB);
  localparam logic [4:0] LAT_MUL_W    = 5'(LAT_MUL);
  localparam logic [4:0] LAT_DIV_W    = 5'(LAT_DIV);
  localparam logic [4:0] LAT_SQRT_W   = 5'(LAT_SQRT);
  localparam logic [4:0] LAT_MISC_W   = 5'(LAT_MISC);

  logic [1:0] state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic       fpu_start_q, fpu_start_d;
  logic [3:0] fpu_op_q, fpu_op_d;
  logic       wb_valid_q, wb_valid_d;
  logic [4:0] wb_rd_q, wb_rd_d;
  logic       wb_float_q, wb_float_d;
  logic       wb_int_q, wb_int_d;
  logic       op_err_q, op_err_d;
  logic       err_q, err_d;

  logic [4:0] lat_sel;
  logic       illegal;

  always_comb begin
    lat_sel = LAT_MISC_W;
    illegal = 1'b0;
    case (op_code)
      4'd0, 4'd1: lat_sel = LAT_ADDSUB_W;
      4'd2:       lat_sel = LAT_MUL_W;
      4'd3:       lat_sel = LAT_DIV_W;
      4'd6:       lat_sel = LAT_SQRT_W;
      4'd4, 4'd5, 4'd7, 4'd8, 4'd9: lat_sel = LAT_MISC_W;
      default: begin
        lat_sel = LAT_MISC_W;
        illegal = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fpu_start_d = 1'b0;
    fpu_op_d    = fpu_op_q;
    wb_valid_d  = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_float_d  = wb_float_q;
    wb_int_d    = wb_int_q;
    op_err_d    = 1'b0;
    err_d       = err_q;

    // Flush beats any issue or completion; latched operands are left alone.
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (issue_valid) begin
            fpu_op_d    = op_code;
            wb_rd_d     = rd;
            wb_float_d  = float_wr;
            wb_int_d    = int_wr;
            err_d       = illegal;
            cnt_d       = lat_sel - 5'd1;
            fpu_start_d = 1'b1;
            state_d     = EXEC;
          end
        end
        EXEC: begin
          if (cnt_q == 5'd0) begin
            state_d    = DONE;
            wb_valid_d = ~err_q;
            op_err_d   = err_q;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 5'd0;
      fpu_start_q <= 1'b0;
      fpu_op_q    <= 4'd0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_float_q  <= 1'b0;
      wb_int_q    <= 1'b0;
      op_err_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fpu_start_q <= fpu_start_d;
      fpu_op_q    <= fpu_op_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_float_q  <= wb_float_d;
      wb_int_q    <= wb_int_d;
      op_err_q    <= op_err_d;
      err_q       <= err_d;
    end
  end

  // stall stays combinational so the accept cycle itself is frozen.
  assign stall     = ((state_q == IDLE) & issue_valid) | (state_q == EXEC);
  assign busy      = (state_q != IDLE);
  assign fpu_start = fpu_start_q;
  assign fpu_op    = fpu_op_q;
  assign wb_valid  = wb_valid_q;
  assign wb_rd     = wb_rd_q;
  assign wb_float  = wb_float_q & wb_valid_q;
  assign wb_int    = wb_int_q & wb_valid_q;
  assign op_err    = op_err_q;

endmodule

// File: tb/tb_fpu_issue_sequencer.sv
// Scoreboard bench for fpu_issue_sequencer: a cycle-indexed timeline model predicts
// each writeback; a separate monitor pops and compares whenever the DUT strobes.
module tb_fpu_issue_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       issue_valid = 1'b0;
  logic [3:0] op_code = 4'd0;
  logic [4:0] rd = 5'd0;
  logic       float_wr = 1'b0;
  logic       int_wr = 1'b0;
  logic       flush = 1'b0;
  logic       stall, fpu_start, busy, wb_valid, wb_float, wb_int, op_err;
  logic [3:0] fpu_op;
  logic [4:0] wb_rd;

  fpu_issue_sequencer dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .op_code(op_code),
    .rd(rd), .float_wr(float_wr), .int_wr(int_wr), .flush(flush),
    .stall(stall), .fpu_start(fpu_start), .fpu_op(fpu_op), .busy(busy),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_float(wb_float), .wb_int(wb_int),
    .op_err(op_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [4:0] rd;
    logic       f;
    logic       i;
    logic       err;
  } wb_t;

  wb_t  exp_q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   chk_en = 0;

  // Timeline model: an op accepted in cycle a with latency L runs EXEC in
  // cycles a+1..a+L and DONE in a+L+1.
  int         acc = -1;
  int         lat = 0;
  logic [3:0] exp_fpu_op = 4'd0;
  bit         rst_chk = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input logic [3:0] op);
    if (op <= 4'd1) return 2;
    if (op == 4'd2) return 3;
    if (op == 4'd3) return 16;
    if (op == 4'd6) return 16;
    return 1;
  endfunction

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  // One cycle: drive inputs, check this cycle's outputs, advance the model.
  task automatic step(input bit iv, input logic [3:0] op, input logic [4:0] r,
                      input bit fw, input bit iw, input bit fl, input bit rs);
    bit idle, exec_now, done_now;
    int c;
    @(negedge clk);
    issue_valid = iv; op_code = op; rd = r; float_wr = fw; int_wr = iw;
    flush = fl; reset = rs;
    #1;
    c = cyc;
    idle     = (acc < 0) || (c >= acc + lat + 2);
    exec_now = (acc >= 0) && (c >= acc + 1) && (c <= acc + lat);
    done_now = (acc >= 0) && (c == acc + lat + 1);
    check("stall", int'(stall), int'((idle && iv) || exec_now));
    check("busy", int'(busy), int'(exec_now || done_now));
    check("fpu_start", int'(fpu_start), int'((acc >= 0) && (c == acc + 1)));
    check("fpu_op", int'(fpu_op), int'(exp_fpu_op));
    if (!done_now)
      check("idle_strobes", int'({wb_valid, op_err, wb_float, wb_int}), 0);
    if (rst_chk) begin
      check("reset_wb_rd", int'(wb_rd), 0);
      rst_chk = 0;
    end
    if (rs || fl) begin
      if (exp_q.size() > 0 && exp_q[$].cyc > c) void'(exp_q.pop_back());
      acc = -1;
      if (rs) begin
        exp_fpu_op = 4'd0;
        rst_chk = 1;
      end
    end else if (idle && iv) begin
      wb_t e;
      acc = c;
      lat = lat_of(op);
      exp_fpu_op = op;
      e.cyc = c + lat + 1;
      e.rd = r;
      e.f = fw;
      e.i = iw;
      e.err = (op >= 4'd10);
      exp_q.push_back(e);
    end
  endtask

  task automatic hold(input int n, input logic [3:0] op, input logic [4:0] r,
                      input bit fw, input bit iw);
    for (int k = 0; k < n; k++) step(1, op, r, fw, iw, 0, 0);
  endtask

  task automatic idle_n(input int n);
    for (int k = 0; k < n; k++) step(0, 4'd0, 5'd0, 0, 0, 0, 0);
  endtask

  // Monitor: pops the next expected writeback whenever the DUT strobes.
  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        tests++;
        fails++;
        $display("FAIL wb_missing: expected writeback in cycle %0d, DUT gave no strobe", exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (wb_valid || op_err) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL wb_unexpected cycle %0d: wb_valid=%0b op_err=%0b with nothing pending",
                   cyc, wb_valid, op_err);
        end else begin
          wb_t e;
          e = exp_q.pop_front();
          check("wb_cycle", cyc, e.cyc);
          check("wb_valid", int'(wb_valid), int'(!e.err));
          check("op_err", int'(op_err), int'(e.err));
          check("wb_rd", int'(wb_rd), int'(e.rd));
          check("wb_float", int'(wb_float), int'(e.f && !e.err));
          check("wb_int", int'(wb_int), int'(e.i && !e.err));
        end
      end
    end
  end

  initial begin
    @(posedge clk);
    @(posedge clk);
    chk_en = 1;
    step(0, 4'd0, 5'd0, 0, 0, 0, 1);
    // FADD
    hold(3, 4'd0, 5'd5, 1, 0);
    hold(1, 4'd0, 5'd5, 1, 0);
    idle_n(2);
    // FDIV then FCMP accepted right after DONE
    hold(17, 4'd3, 5'd2, 1, 0);
    hold(1, 4'd3, 5'd2, 1, 0);
    hold(2, 4'd7, 5'd9, 0, 1);
    hold(1, 4'd7, 5'd9, 0, 1);
    idle_n(2);
    // FSQRT flushed in EXEC cycle 5
    hold(5, 4'd6, 5'd3, 1, 0);
    step(1, 4'd6, 5'd3, 1, 0, 1, 0);
    idle_n(20);
    // Illegal code
    hold(2, 4'd12, 5'd7, 1, 1);
    hold(1, 4'd12, 5'd7, 1, 1);
    idle_n(2);
    // Reset (with flush) during FMUL EXEC cycle 2, then a fresh FMUL
    hold(2, 4'd2, 5'd11, 1, 0);
    step(1, 4'd2, 5'd11, 1, 0, 1, 1);
    hold(4, 4'd2, 5'd12, 1, 0);
    hold(1, 4'd2, 5'd12, 1, 0);
    idle_n(2);
    // Flush vs issue in IDLE, then flush drops with issue still held
    step(1, 4'd1, 5'd4, 1, 0, 1, 0);
    step(1, 4'd1, 5'd4, 1, 0, 1, 0);
    hold(3, 4'd1, 5'd4, 1, 0);
    hold(1, 4'd1, 5'd4, 1, 0);
    idle_n(2);
    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      step(($urandom % 3) != 0, 4'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
           ($urandom % 40) == 0, ($urandom % 150) == 0);
    end
    idle_n(25);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fpu_issue_sequencer.md
# fpu_issue_sequencer

Multi-cycle issue and writeback sequencer for the floating-point unit. It consumes the 4-bit `{fpuOp,aluOp}` operation code and the register-write controls produced by instruction decode. It holds the pipeline stalled for the operation's fixed latency, pulses the FPU start strobe, and then emits a single writeback strobe to the float or integer register file. It sits in the EX stage between decode and the FPU datapath.

## Interface
Parameters:
- `LAT_ADDSUB`, default 2: EXEC cycles for codes 0 (FADD.S) and 1 (FSUB.S).
- `LAT_MUL`, default 3: EXEC cycles for code 2 (FMUL.S).
- `LAT_DIV`, default 16: EXEC cycles for code 3 (FDIV.S).
- `LAT_SQRT`, default 16: EXEC cycles for code 6 (FSQRT.S).
- `LAT_MISC`, default 1: EXEC cycles for codes 4, 5, 7, 8 and 9 (sign-inject, min/max, compare, FCVT.W.S, FCVT.S.W).
- All latencies must lie in the range 1..31. The counter is 5 bits wide.

Ports:
- `clk`, in, 1: the single clock; every register updates on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `issue_valid`, in, 1: an FP operation is present in EX (decode fpuOp bit = 1).
- `op_code`, in, 4: the `{fpuOp,aluOp}` code.
- `rd`, in, 5: destination register index.
- `float_wr`, in, 1: result goes to the float register file.
- `int_wr`, in, 1: result goes to the integer register file.
- `flush`, in, 1: synchronous abort of the in-flight operation.
- `stall`, out, 1: freezes IF/ID/EX. This is the only combinational output.
- `fpu_start`, out, 1: one-cycle start strobe to the FPU datapath.
- `fpu_op`, out, 4: latched op_code driven to the FPU.
- `busy`, out, 1: high while the state is not IDLE.
- `wb_valid`, out, 1: one-cycle writeback strobe.
- `wb_rd`, out, 5: latched rd.
- `wb_float`, out, 1: latched float_wr, qualified by wb_valid.
- `wb_int`, out, 1: latched int_wr, qualified by wb_valid.
- `op_err`, out, 1: one-cycle strobe in DONE when the code was illegal (10..15).

## Operation
- FSM states are IDLE, EXEC and DONE. The counter `cnt` is 5 bits wide.
- **IDLE**
  - When `issue_valid`=1: latch op_code, rd, float_wr and int_wr.
  - Load `cnt` with LAT(op)-1, set `fpu_start`=1 for the next cycle, and go to EXEC.
  - Illegal codes use LAT_MISC and are latched with an error flag.
- **EXEC**
  - `fpu_start` is high only in the first EXEC cycle.
  - If `cnt`==0, go to DONE; otherwise decrement `cnt`.
- **DONE**
  - Lasts exactly one cycle, then the FSM returns to IDLE unconditionally.
  - Legal code: `wb_valid`=1 and `op_err`=0.
  - Illegal code: `wb_valid`=0 and `op_err`=1.
  - `issue_valid` is ignored in DONE, because it still reflects the completing instruction.
- `stall` = (state==IDLE & issue_valid) | (state==EXEC). It is low in DONE, which is the cycle in which the pipeline advances.
- **Flush:** `flush`=1 in any state forces IDLE on the next edge.
  - `fpu_start`, `wb_valid` and `op_err` are 0 in the cycle after the flush.
  - A flush in IDLE with `issue_valid`=1 blocks acceptance. Flush has priority over issue.
- **Reset:** `reset` has priority over `flush`. Mid-operation it behaves like a flush.
  - Registered output values after reset: state IDLE, `busy`=0, `fpu_start`=0, `fpu_op`=0, `wb_valid`=0, `wb_rd`=0, `wb_float`=0, `wb_int`=0, `op_err`=0, `cnt`=0.
- `wb_float` and `wb_int` are driven as the latched value AND `wb_valid`, so both are 0 outside DONE.

## Timing
- An operation with latency L, accepted at edge k (state IDLE, `issue_valid` sampled high):
  - `stall` is high for the accept cycle plus the L EXEC cycles, i.e. L+1 cycles.
  - DONE and `wb_valid` occupy cycle k+L+1.
  - The next issue can be accepted at edge k+L+2 at the earliest.
- `fpu_start` is high in cycle k+1 only. `fpu_op` is stable from k+1 until the next accept.
- The FPU datapath must present its result by the DONE cycle; the sequencer does not wait on a done handshake.
- `busy` is high for exactly L+1 cycles per operation.

## Test plan
- **FADD:** `reset`, then issue op 0, rd=5, float_wr=1.
  - Required: `stall` is high for 3 cycles and `fpu_start` is pulsed in cycle 1.
  - Required: `wb_valid`=1, `wb_rd`=5, `wb_float`=1 and `wb_int`=0 in cycle 3, then `busy`=0.
- **FDIV and back-to-back:** issue op 3, immediately followed by op 7 (FCMP) with int_wr=1, rd=9.
  - Required: the first `wb_valid` occurs 17 cycles after accept, with `stall` high for 17 cycles.
  - Required: FCMP is accepted in the cycle after DONE, and `wb_valid` with `wb_int`=1 and `wb_rd`=9 follows 2 cycles later.
- **Flush:** issue op 6 (FSQRT) and assert `flush` in EXEC cycle 5.
  - Required: state is IDLE next cycle, with `stall`=0 and `busy`=0.
  - Required: no `wb_valid` for the following 20 cycles.
- **Illegal code:** issue op 12.
  - Required: `stall` is high for 2 cycles, then DONE with `op_err`=1, `wb_valid`=0, `wb_float`=0 and `wb_int`=0.
- **Reset mid-operation:** assert `reset` during FMUL EXEC cycle 2, with `flush` also high.
  - Required: all outputs take their reset values next cycle.
  - Required: a fresh FMUL issued afterwards completes in exactly 4 cycles from accept to `wb_valid`.
- **Flush vs. issue:** assert `issue_valid` and `flush` together in IDLE.
  - Required: no accept and no `fpu_start`.
  - Required: when `issue_valid` is held and `flush` drops, the accept happens that cycle.
